// File: rtl/fetch_unit.sv
// Instruction fetch/decode front end over a 1-cycle synchronous instruction memory.
// Optional jump support is enabled with `define FETCH_JUMP_EN.
module fetch_unit #(
    parameter int INS_MEMORY_SIZE  = 32,
    parameter int DATA_MEMORY_SIZE = 64,
    parameter int OPCODE_WIDTH     = 2,
    parameter int HALT_OPCODE      = 0,
    localparam int PC_W   = $clog2(INS_MEMORY_SIZE),
    localparam int ADDR_W = $clog2(DATA_MEMORY_SIZE),
    localparam int WIDTH  = OPCODE_WIDTH + 3 * ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic [PC_W-1:0]         imem_addr,
    input  logic [WIDTH-1:0]        imem_data,
    input  logic                    ready,
    output logic                    valid,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [ADDR_W-1:0]       dst,
    output logic [ADDR_W-1:0]       src2,
    output logic [ADDR_W-1:0]       src1,
    output logic [PC_W-1:0]         pc,
    output logic                    finished
`ifdef FETCH_JUMP_EN
    ,
    input  logic                    jump,
    input  logic [PC_W-1:0]         jump_target
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        HOLD,
        DONE
    } state_t;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(INS_MEMORY_SIZE - 1);
    localparam logic [OPCODE_WIDTH-1:0] HALT = OPCODE_WIDTH'(HALT_OPCODE);

    state_t                  state_q, state_d;
    logic [PC_W-1:0]         pc_q, pc_d;
    logic                    valid_q, valid_d;
    logic                    finished_q, finished_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [ADDR_W-1:0]       dst_q, dst_d;
    logic [ADDR_W-1:0]       src2_q, src2_d;
    logic [ADDR_W-1:0]       src1_q, src1_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        finished_d = finished_q;
        opcode_d   = opcode_q;
        dst_d      = dst_q;
        src2_d     = src2_q;
        src1_d     = src1_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = REQ;
            end
            REQ: begin
                state_d = CAP;
            end
            CAP: begin
                opcode_d = imem_data[WIDTH-1 -: OPCODE_WIDTH];
                dst_d    = imem_data[3*ADDR_W-1 -: ADDR_W];
                src2_d   = imem_data[2*ADDR_W-1 -: ADDR_W];
                src1_d   = imem_data[ADDR_W-1:0];
                valid_d  = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                if (ready) begin
                    valid_d = 1'b0;
                    if (opcode_q == HALT) begin
                        state_d    = DONE;
                        finished_d = 1'b1;
                    end
`ifdef FETCH_JUMP_EN
                    else if (jump) begin
                        // Out-of-range target ends the program rather than aliasing.
                        if ({1'b0, jump_target} >= (PC_W+1)'(INS_MEMORY_SIZE)) begin
                            state_d    = DONE;
                            finished_d = 1'b1;
                        end else begin
                            pc_d    = jump_target;
                            state_d = enable ? REQ : IDLE;
                        end
                    end
`endif
                    else if (pc_q == LAST_PC) begin
                        state_d    = DONE;
                        finished_d = 1'b1;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = enable ? REQ : IDLE;
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d    = IDLE;
                    finished_d = 1'b0;
                    pc_d       = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            finished_q <= 1'b0;
            opcode_q   <= '0;
            dst_q      <= '0;
            src2_q     <= '0;
            src1_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            finished_q <= finished_d;
            opcode_q   <= opcode_d;
            dst_q      <= dst_d;
            src2_q     <= src2_d;
            src1_q     <= src1_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign valid     = valid_q;
    assign finished  = finished_q;
    assign opcode    = opcode_q;
    assign dst       = dst_q;
    assign src2      = src2_q;
    assign src1      = src1_q;

endmodule
